button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Upstream conditioning stage for the on-board push buttons.
- Takes raw, asynchronous, bouncing button pins and synchronises each one into the clk domain.
- Filters each button with a stability counter.
- Outputs a clean level per button plus single-cycle press/release strobes.
- Sits between the BUT pins and the edge-detect/LED logic, which consume its clean levels instead of raw pins.

Parameters:
- NUM_BUTTONS, 2: number of independent button channels.
- DEBOUNCE_CYCLES, 1000000: cycles an input must stay stable before it is accepted (10 ms at 100 MHz). Legal minimum is 2.
- SYNC_STAGES, 2: synchroniser flip-flop depth per channel. Legal minimum is 2.
- HOLD_CYCLES, 50000000: cycles a press must persist before btn_hold asserts (0.5 s). Used only with the optional feature.

Ports:
- clk  input  1  100 MHz system clock.
- rst_n  input  1  asynchronous, active-low reset.
- btn_raw  input  NUM_BUTTONS  raw button pins, active-high, asynchronous to clk.
- btn_level  output  NUM_BUTTONS  debounced button state.
- btn_press  output  NUM_BUTTONS  one-cycle pulse when btn_level goes 0->1.
- btn_release  output  NUM_BUTTONS  one-cycle pulse when btn_level goes 1->0.
- btn_hold  output  NUM_BUTTONS  long-press indicator. Present only with BUTTON_DEBOUNCE_HOLD_EN.

Behaviour:
- The design uses one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear on the falling edge of rst_n, independent of clk.
- Reset values: synchroniser chain 0, btn_level 0, btn_press 0, btn_release 0, btn_hold 0, all counters 0.
- Channels are fully independent; there is no shared state between buttons.
- Synchroniser: btn_raw[i] passes through SYNC_STAGES flops. The last stage is the value sync[i].
- Counter width is clog2(DEBOUNCE_CYCLES) bits and saturates at no point. It clears instead of wrapping.
- States per channel (implicit FSM):
  - STABLE: sync == btn_level. Counter is held at 0.
  - PENDING: sync != btn_level. Counter increments by 1 each cycle.
- Transitions:
  - PENDING -> STABLE (accept): counter == DEBOUNCE_CYCLES-1 and sync still != btn_level. On the next edge, btn_level <= sync and counter <= 0. The matching press or release pulse is high for exactly that one cycle.
  - PENDING -> STABLE (reject): sync returns to btn_level before the count completes. Counter clears, no output change, no pulse.
- Bounce handling: any bounce restarts the count from 0. The input must be continuously different for DEBOUNCE_CYCLES cycles to be accepted.
- Latency: a clean step on btn_raw appears on btn_level SYNC_STAGES+DEBOUNCE_CYCLES cycles later, ±1 cycle for asynchronous sampling.
- Pulse exclusivity: btn_press and btn_release for the same channel are never high in the same cycle.
- Minimum pulse spacing: consecutive pulses on one channel are at least DEBOUNCE_CYCLES cycles apart.
- Reset mid-operation: any pending count is discarded and btn_level returns to 0. A button held through reset is re-accepted, with a btn_press pulse, SYNC_STAGES+DEBOUNCE_CYCLES cycles after rst_n deasserts.
- Simultaneous events: buttons changing in the same cycle are each accepted on their own count and may pulse in the same cycle.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_HOLD_EN.
- With the macro defined:
  - A per-channel hold counter runs while btn_level==1.
  - btn_hold[i] asserts in the cycle after the counter reaches HOLD_CYCLES-1 and stays high until btn_level falls.
  - btn_hold and the hold counter clear in the same cycle that btn_release pulses.
- Without the macro: the btn_hold port, hold counters and HOLD_CYCLES logic do not exist.

Decomposition:
- Shared package button_pkg holds:
  - default constants CLK_HZ=100000000, DEBOUNCE_MS=10 and HOLD_MS=500;
  - a helper constant function converting ms to cycles.
- Sub-module debounce_channel contains one synchroniser, the counter and the pulse logic for a single button.
- The top-level instantiates debounce_channel NUM_BUTTONS times with a generate loop.

Test Plan:
All tests use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, HOLD_CYCLES=20.
- Clean press: raise btn_raw[0] and hold -> btn_level[0] rises 10±1 cycles later; btn_press[0] is high for 1 cycle; btn_release stays 0.
- Bounce rejected: toggle btn_raw[0] 1/0 every 3 cycles for 30 cycles, then hold at 0 -> btn_level stays 0; no pulses.
- Bounce then settle: glitch for 5 cycles, then hold at 1 -> exactly one btn_press, 8 cycles after the last glitch plus sync delay.
- Release with two buttons: release btn_raw[0] while btn_raw[1] is pressed in the same cycle -> btn_release[0] and btn_press[1] pulse in the same cycle.
- Reset mid-count: assert rst_n=0 at count 5 while btn_raw=1, then release reset -> outputs are 0 during reset; btn_press occurs 10 cycles after deassertion.
- Hold (macro defined): hold pressed for 40 cycles after acceptance -> btn_hold rises 20 cycles after btn_press; it drops with btn_release on release.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: shared clock/timing constants, ms-to-cycles helper and channel state type for the button debouncer
package button_pkg;
  localparam int CLK_HZ      = 100000000;
  localparam int DEBOUNCE_MS = 10;
  localparam int HOLD_MS     = 500;
  typedef enum logic {STABLE, PENDING} chan_state_e;
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction
endpackage

// File: rtl/button_debounce_if.sv
// button_debounce_if: raw pins in, clean levels and press/release (and optional hold) strobes out
//   master: drives btn_raw, observes the conditioned outputs
//   slave : the debouncer, consumes btn_raw and drives the outputs
//   btn_hold exists only when BUTTON_DEBOUNCE_HOLD_EN is defined
interface button_debounce_if #(parameter int NUM_BUTTONS = 2);
  logic [NUM_BUTTONS-1:0] btn_raw;
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
`ifdef BUTTON_DEBOUNCE_HOLD_EN
  logic [NUM_BUTTONS-1:0] btn_hold;
  modport master (output btn_raw, input btn_level, btn_press, btn_release, btn_hold);
  modport slave  (input btn_raw, output btn_level, btn_press, btn_release, btn_hold);
`else
  modport master (output btn_raw, input btn_level, btn_press, btn_release);
  modport slave  (input btn_raw, output btn_level, btn_press, btn_release);
`endif
endinterface

// File: rtl/button_debounce_channel.sv
// debounce_channel: synchroniser, stability counter and press/release (optional hold) logic for one button
//   clk, rst_n (async, active-low), btn_raw in; btn_level, btn_press, btn_release out
//   btn_hold out and HOLD_CYCLES only with BUTTON_DEBOUNCE_HOLD_EN
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
`ifdef BUTTON_DEBOUNCE_HOLD_EN
  , parameter int HOLD_CYCLES   = 50000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
`ifdef BUTTON_DEBOUNCE_HOLD_EN
  , output logic btn_hold
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic s, acc;
  chan_state_e st;
  assign s   = sync_q[SYNC_STAGES-1];
  assign st  = (s == btn_level) ? STABLE : PENDING;
  assign acc = (st == PENDING) && (cnt == LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  // any return to the accepted level restarts the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      cnt         <= (st == STABLE || acc) ? '0 : cnt + 1'b1;
      btn_level   <= acc ? s : btn_level;
      btn_press   <= acc && s;
      btn_release <= acc && !s;
    end
`ifdef BUTTON_DEBOUNCE_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
  logic [HW-1:0] hcnt;
  // hold counter parks at HLAST once btn_hold is set; cleared on the release accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt     <= '0;
      btn_hold <= 1'b0;
    end else if (acc && btn_level) begin
      hcnt     <= '0;
      btn_hold <= 1'b0;
    end else if (btn_level && !btn_hold) begin
      hcnt     <= (hcnt == HLAST) ? hcnt : hcnt + 1'b1;
      btn_hold <= hcnt == HLAST;
    end
`endif
endmodule

// File: rtl/button_debounce.sv
// button_debounce: per-button synchronise + debounce with clean level and one-cycle press/release strobes
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : button_debounce_if.slave (btn_raw in; btn_level, btn_press, btn_release out)
//   Define BUTTON_DEBOUNCE_HOLD_EN to add btn_hold (long-press) and the HOLD_CYCLES parameter.
module button_debounce
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int SYNC_STAGES     = 2
`ifdef BUTTON_DEBOUNCE_HOLD_EN
  , parameter int HOLD_CYCLES   = ms_to_cycles(HOLD_MS)
`endif
) (
  input logic           clk,
  input logic           rst_n,
  button_debounce_if.slave bus
);
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
`ifdef BUTTON_DEBOUNCE_HOLD_EN
      , .HOLD_CYCLES  (HOLD_CYCLES)
`endif
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (bus.btn_raw[i]),
      .btn_level  (bus.btn_level[i]),
      .btn_press  (bus.btn_press[i]),
      .btn_release(bus.btn_release[i])
`ifdef BUTTON_DEBOUNCE_HOLD_EN
      , .btn_hold (bus.btn_hold[i])
`endif
    );
  end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed and random stimulus checked against a sample-window reference model
module tb_button_debounce;
  localparam int N  = 2;
  localparam int DC = 8;
  localparam int SS = 2;
  localparam int HC = 20;
  localparam int DEPTH = SS + DC;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  button_debounce_if #(.NUM_BUTTONS(N)) bus ();
  button_debounce #(
    .NUM_BUTTONS(N), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)
`ifdef BUTTON_DEBOUNCE_HOLD_EN
    , .HOLD_CYCLES(HC)
`endif
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // model: raw samples taken at each edge, newest at index 0; an edge accepts a
  // channel when the DC synchronised samples ending at that edge all differ from the level
  logic [N-1:0] rh [0:DEPTH-1];
  logic [N-1:0] m_lvl, m_press, m_rel, m_hold;
  int hup [N];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int j = 0; j < DEPTH; j++) rh[j] = '0;
    m_lvl = '0; m_press = '0; m_rel = '0; m_hold = '0;
    for (int i = 0; i < N; i++) hup[i] = 0;
  endtask
  task automatic model_edge(input logic [N-1:0] raw);
    for (int j = DEPTH - 1; j > 0; j--) rh[j] = rh[j-1];
    rh[0] = raw;
    for (int i = 0; i < N; i++) begin
      bit acc = 1;
      for (int m = 0; m < DC; m++) if (rh[m+SS][i] == m_lvl[i]) acc = 0;
      m_press[i] = acc && !m_lvl[i];
      m_rel[i]   = acc && m_lvl[i];
      if (m_rel[i]) begin
        hup[i] = 0;
        m_hold[i] = 1'b0;
      end else if (m_lvl[i]) begin
        hup[i]++;
        if (hup[i] >= HC) m_hold[i] = 1'b1;
      end
      if (acc) m_lvl[i] = ~m_lvl[i];
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge(bus.btn_raw);
    @(negedge clk);
    check("level", 32'(bus.btn_level), 32'(m_lvl));
    check("press", 32'(bus.btn_press), 32'(m_press));
    check("release", 32'(bus.btn_release), 32'(m_rel));
    check("exclusive", 32'(bus.btn_press & bus.btn_release), 32'd0);
`ifdef BUTTON_DEBOUNCE_HOLD_EN
    check("hold", 32'(bus.btn_hold), 32'(m_hold));
`endif
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_level"}, 32'(bus.btn_level), 32'd0);
    check({tag, "_press"}, 32'(bus.btn_press), 32'd0);
    check({tag, "_release"}, 32'(bus.btn_release), 32'd0);
`ifdef BUTTON_DEBOUNCE_HOLD_EN
    check({tag, "_hold"}, 32'(bus.btn_hold), 32'd0);
`endif
  endtask
  int lat, lat2, pulses;
  initial begin
    bus.btn_raw = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (3) step();
    // clean press on channel 0
    bus.btn_raw = 2'b01;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step();
      if (bus.btn_level[0]) begin
        lat = c;
        check("press_pulse", 32'(bus.btn_press[0]), 32'd1);
      end
    end
    check("press_latency", lat, 10);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
`ifdef BUTTON_DEBOUNCE_HOLD_EN
      if (bus.btn_hold[0] && lat == 0) lat = c;
`endif
    end
`ifdef BUTTON_DEBOUNCE_HOLD_EN
    check("hold_latency", lat, HC);
`endif
    // release channel 0 while pressing channel 1 in the same cycle
    bus.btn_raw = 2'b10;
    lat = 0; lat2 = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus.btn_release[0]) lat = c;
      if (bus.btn_press[1]) lat2 = c;
`ifdef BUTTON_DEBOUNCE_HOLD_EN
      if (bus.btn_release[0]) check("hold_clear", 32'(bus.btn_hold[0]), 32'd0);
`endif
    end
    check("release0_latency", lat, 10);
    check("press1_latency", lat2, 10);
    // bounce rejected on channel 0
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      bus.btn_raw[0] = ((c / 3) % 2) == 0;
      step();
      pulses += int'(bus.btn_press[0]) + int'(bus.btn_release[0]);
    end
    bus.btn_raw[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      pulses += int'(bus.btn_press[0]) + int'(bus.btn_release[0]);
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_level", 32'(bus.btn_level[0]), 32'd0);
    // glitch then settle high
    for (int c = 0; c < 5; c++) begin
      bus.btn_raw[0] = (c % 2) == 0 && c < 4;
      step();
    end
    bus.btn_raw[0] = 1'b1;
    lat = 0; pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.btn_press[0]) begin
        pulses++;
        if (lat == 0) lat = c;
      end
    end
    check("settle_latency", lat, 10);
    check("settle_pulses", pulses, 1);
    // reset mid-count
    bus.btn_raw = 2'b00;
    repeat (20) step();
    bus.btn_raw = 2'b01;
    repeat (SS + 5) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    check_zero("midreset_hold");
    rst_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step();
      if (bus.btn_press[0]) lat = c;
    end
    check("reset_repress_latency", lat, 10);
    // random segments
    for (int k = 0; k < 200; k++) begin
      int dur;
      bus.btn_raw = N'($urandom_range(0, 3));
      dur = $urandom_range(1, 14);
      repeat (dur) step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
